piso_serializer: RTL
====================

# piso_serializer

Parallel-in serial-out serializer that accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock on `so`. It sits directly upstream of the single-bit serial register stage and drives that stage's `si` input. It supports gapless back-to-back frames and an optional appended even-parity bit.

## Interface
- `WIDTH`, 8: word width in bits; legal range is 2 to 32.
- `MSB_FIRST`, 1: 1 means bit WIDTH-1 is transmitted first; 0 means bit 0 is transmitted first.
- `clk  input  1  clock`; all state changes on the rising edge.
- `rst  input  1  reset`: asynchronous, active-low; clears state immediately while low.
- `load_valid  input  1  din` holds a word to serialize.
- `load_ready  output  1`: the block can accept a word this cycle.
- `din  input  WIDTH  parallel word`; sampled only on an accepted load.
- `so  output  1`: serial data, registered; drives the downstream `si`.
- `so_valid  output  1`: `so` carries a frame bit this cycle.
- `busy  output  1`: a frame is in progress.
- `done  output  1`: one-cycle pulse, coincident with the last bit of the frame on `so`.

## Operation
- State machine states:
  - IDLE: no frame in progress.
  - SHIFT: data bits are being transmitted.
  - PARITY: parity bit is transmitted; this state exists only when the parity macro is defined.
- Load acceptance:
  - A load is accepted when `load_valid` and `load_ready` are both high at a rising edge.
  - `load_ready` = 1 in IDLE.
  - `load_ready` = 1 in the final bit cycle of a frame, which is the last SHIFT cycle or the PARITY cycle.
  - `load_ready` = 0 in all other cycles.
  - `load_ready` = 0 while `rst` is low.
- On accept:
  - `din` is copied into the shift register.
  - The bit counter is set to WIDTH-1.
  - State goes to SHIFT.
  - The first bit appears on `so` in the next cycle.
- In SHIFT:
  - Each clock the register shifts one position toward the output end (toward MSB if MSB_FIRST=1, else toward LSB).
  - The counter decrements by 1 each clock.
  - When the counter = 0 and that bit is on `so`, the frame ends, unless parity is enabled (then the frame continues in PARITY).
- End of frame:
  - If a load is accepted in the final bit cycle, the next frame starts immediately and there is no idle gap.
  - Otherwise the state returns to IDLE, with `so` = 0 and `so_valid` = 0.
- Loads are ignored while `load_ready` = 0. `din` changes in that window have no effect.
- Counter width: $clog2(WIDTH) bits. The counter never wraps; a frame always ends at 0.
- Reset mid-frame: the frame is abandoned, no `done` pulse is produced, and the next frame starts clean.

## Timing
- Reset values: `so`=0, `so_valid`=0, `busy`=0, `done`=0, state IDLE, counter 0, shift register 0.
- Latency: accept edge at cycle 0; first bit on `so` at cycle 1; last data bit at cycle WIDTH; parity bit, when enabled, at cycle WIDTH+1.
- `so_valid` and `busy` are high on exactly the frame's bit cycles.
- `done` is high only on the final bit cycle.
- Throughput: one frame every WIDTH cycles, or WIDTH+1 cycles with parity, when back-to-back.
- All outputs are registered except `load_ready`, which is combinational from state, counter and `rst`.

## Configuration
- `PISO_PARITY_EN` defined:
  - After the last data bit, one PARITY cycle outputs the XOR of all WIDTH bits of the accepted word, which gives even parity.
  - `done` and the back-to-back `load_ready` move to the PARITY cycle.
  - The parity value is computed at accept time and held in a 1-bit register.
- `PISO_PARITY_EN` undefined:
  - The PARITY state, the parity register and the parity logic are absent.
  - The frame is exactly WIDTH bits.

## Structure
- Shared package `serial_pkg` holds:
  - the state encoding constants `ST_IDLE`, `ST_SHIFT`, `ST_PARITY` (2-bit);
  - the default width constant `SERIAL_WIDTH_DEF` = 8.
- One sub-module, `parity_gen`: a combinational WIDTH-input XOR reduction, instantiated only under `PISO_PARITY_EN`.
- Shift register, counter and FSM stay in `piso_serializer`.

## Test plan
- Basic frame, WIDTH=8, MSB_FIRST=1, no parity, `din`=8'hA5 accepted at cycle 0:
  - `so` = 1,0,1,0,0,1,0,1 on cycles 1–8;
  - `so_valid` high on cycles 1–8;
  - `done` high on cycle 8 only;
  - IDLE at cycle 9 with `so`=0.
- LSB-first, MSB_FIRST=0, `din`=8'h01:
  - `so` = 1,0,0,0,0,0,0,0 on cycles 1–8.
- Back-to-back, no parity:
  - `load_valid` held high with 8'hA5, then 8'h3C presented at cycle 8;
  - 8'h3C is accepted at cycle 8;
  - `so` = 0,0,1,1,1,1,0,0 on cycles 9–16;
  - `so_valid` never drops between frames.
- Busy rejection:
  - `din`=8'hFF with `load_valid` high at cycle 3 of an 8'hA5 frame;
  - `load_ready`=0, the word is ignored, and the 8'hA5 bit sequence is unchanged.
- Reset mid-frame:
  - `rst` driven low at cycle 4 of a frame;
  - all outputs go to 0 immediately and no `done` pulse occurs;
  - after release, 8'h80 loads and `so` = 1 then 0 ×7.
- `PISO_PARITY_EN` defined:
  - `din`=8'hA5 gives parity 0 on cycle 9, with `done` on cycle 9;
  - `din`=8'h07 gives parity 1 on cycle 9.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial datapath blocks: FSM state encoding
// and the default serializer word width.
package serial_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;

  localparam int SERIAL_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_SHIFT  = ST_SHIFT,
    S_PARITY = ST_PARITY
  } state_t;

endpackage

// File: rtl/piso_serializer_parity_gen.sv
// parity_gen: combinational XOR reduction over a WIDTH-bit word.
// A result of 1 means the word holds an odd number of ones, so appending
// it to the word makes the total count of ones even.
module parity_gen #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_data,
  output logic             o_parity
);

  assign o_parity = ^i_data;

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out shifter with a valid/ready load
// port, gapless back-to-back frames and a registered serial output.
// Optional feature macro: PISO_PARITY_EN appends one even-parity bit
// after the data bits of every frame.
module piso_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH     = SERIAL_WIDTH_DEF,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] din,
  output logic             so,
  output logic             so_valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int OUT_IDX = MSB_FIRST ? WIDTH - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_stateNext;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shiftNext;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cntNext;
  logic             r_so;
  logic             r_soValid;
  logic             r_busy;
  logic             r_done;
  logic             w_soNext;
  logic             w_busyNext;
  logic             w_doneNext;
  logic             w_finalBit;
  logic             w_accept;

`ifdef PISO_PARITY_EN
  logic r_parity;
  logic w_parityNext;
  logic w_parityCalc;

  parity_gen #(
    .WIDTH(WIDTH)
  ) u_parityGen (
    .i_data  (din),
    .o_parity(w_parityCalc)
  );

  assign w_finalBit = (r_state == S_PARITY);
`else
  assign w_finalBit = (r_state == S_SHIFT) && (r_cnt == '0);
`endif

  // Ready when idle or on the last bit of a frame so the next word follows without a gap.
  assign load_ready = rst && ((r_state == S_IDLE) || w_finalBit);
  assign w_accept   = load_valid && load_ready;

  // Next-state, datapath and next-output decode; an accepted load overrides everything else.
  always_comb begin
    w_stateNext = r_state;
    w_shiftNext = r_shift;
    w_cntNext   = r_cnt;
`ifdef PISO_PARITY_EN
    w_parityNext = r_parity;
`endif
    w_soNext   = 1'b0;
    w_busyNext = 1'b0;
    w_doneNext = 1'b0;

    case (r_state)
      S_IDLE: begin
      end
      S_SHIFT: begin
        if (r_cnt != '0) begin
          if (MSB_FIRST) begin
            w_shiftNext = {r_shift[WIDTH-2:0], 1'b0};
          end else begin
            w_shiftNext = {1'b0, r_shift[WIDTH-1:1]};
          end
          w_cntNext = r_cnt - CNT_W'(1);
        end else begin
`ifdef PISO_PARITY_EN
          w_stateNext = S_PARITY;
`else
          w_stateNext = S_IDLE;
          w_shiftNext = '0;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      S_PARITY: begin
        w_stateNext = S_IDLE;
        w_shiftNext = '0;
      end
`endif
      default: begin
        w_stateNext = S_IDLE;
        w_shiftNext = '0;
        w_cntNext   = '0;
      end
    endcase

    if (w_accept) begin
      w_stateNext = S_SHIFT;
      w_shiftNext = din;
      w_cntNext   = CNT_FIRST;
`ifdef PISO_PARITY_EN
      w_parityNext = w_parityCalc;
`endif
    end

    if (w_stateNext == S_SHIFT) begin
      w_soNext   = w_shiftNext[OUT_IDX];
      w_busyNext = 1'b1;
`ifndef PISO_PARITY_EN
      w_doneNext = (w_cntNext == '0);
`endif
    end
`ifdef PISO_PARITY_EN
    if (w_stateNext == S_PARITY) begin
      w_soNext   = w_parityNext;
      w_busyNext = 1'b1;
      w_doneNext = 1'b1;
    end
`endif
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Shift register, bit counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift   <= '0;
      r_cnt     <= '0;
      r_so      <= 1'b0;
      r_soValid <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_shift   <= w_shiftNext;
      r_cnt     <= w_cntNext;
      r_so      <= w_soNext;
      r_soValid <= w_busyNext;
      r_busy    <= w_busyNext;
      r_done    <= w_doneNext;
    end
  end

`ifdef PISO_PARITY_EN
  // Parity of the accepted word, captured at load and held for the parity cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_parity <= 1'b0;
    end else begin
      r_parity <= w_parityNext;
    end
  end
`endif

  assign so       = r_so;
  assign so_valid = r_soValid;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
